fetch_unit: RTL and testbench

Instruction fetch stage of the RV64 core: holds the program counter, issues one-outstanding-request reads to instruction memory, and presents each fetched instruction with its PC to decode through a valid/ready output register. `if_opcode` drives the opcode input of `control_unit` directly. Taken branches resolved downstream redirect the PC and squash any in-flight or buffered fetch.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit_if_id_reg.sv | 53 +++++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared RV64 core constants, opcode values and fetch FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ISSUE must encode as zero so the reset state is the all-zero vector.
  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Instruction-memory, redirect and decode-side signals of the
//            fetch stage. master = fetch unit, slave = its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  import riscv_pkg::*;

  logic                imem_req;
  logic [XLEN-1:0]     imem_addr;
  logic                imem_valid;
  logic [INSTR_W-1:0]  imem_rdata;
  logic                branch_taken;
  logic [XLEN-1:0]     branch_target;
  logic                id_ready;
  logic                if_valid;
  logic [INSTR_W-1:0]  if_instr;
  logic [XLEN-1:0]     if_pc;
  logic [6:0]          if_opcode;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode,
    input  imem_valid, imem_rdata, branch_taken, branch_target, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode,
    output imem_valid, imem_rdata, branch_taken, branch_target, id_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : Valid/ready output register between fetch and decode. Load fills
//            it, hold keeps it while decode stalls, squash empties it.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
  import riscv_pkg::*;
(
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                i_load,
  input  wire logic                i_hold,
  input  wire logic                i_squash,
  input  wire logic [INSTR_W-1:0]  i_instr,
  input  wire logic [XLEN-1:0]     i_pc,
  output logic                     o_valid,
  output logic [INSTR_W-1:0]       o_instr,
  output logic [XLEN-1:0]          o_pc
);

  logic                r_valid;
  logic [INSTR_W-1:0]  r_instr;
  logic [XLEN-1:0]     r_pc;

  // Squash beats load; without load, an un-held entry is consumed and clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else begin
      if (i_squash)
        r_valid <= 1'b0;
      else if (i_load)
        r_valid <= 1'b1;
      else if (!i_hold)
        r_valid <= 1'b0;

      if (i_load && !i_squash) begin
        r_instr <= i_instr;
        r_pc    <= i_pc;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : RV64 instruction fetch: PC, one-outstanding imem request,
//            branch redirect/squash and the decode-facing output register.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
)
(
  input  wire logic    clk,
  input  wire logic    rst,
  fetch_unit_if.master bus
);

  localparam logic [XLEN-1:0] C_PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] C_WORD_MASK = ~XLEN'(3);

  fetch_state_t     r_state;
  fetch_state_t     w_state_next;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  w_pc_next;
  logic [XLEN-1:0]  w_target;
  logic             w_req;
  logic             w_load;

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ISSUE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Next-state, request and PC update; a branch overrides capture and issue.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_load       = 1'b0;
    w_target     = bus.branch_target & C_WORD_MASK;
    // Issue only when the output register is empty or being drained now.
    w_req        = (r_state == ST_ISSUE) && !rst && !bus.branch_taken &&
                   (!bus.if_valid || bus.id_ready);

    case (r_state)
      ST_ISSUE: begin
        if (w_req)
          w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.branch_taken) begin
          // A response in the branch cycle is simply dropped.
          w_state_next = bus.imem_valid ? ST_ISSUE : ST_DRAIN;
        end else if (bus.imem_valid) begin
          w_load       = 1'b1;
          w_pc_next    = r_pc + C_PC_STEP;
          w_state_next = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (bus.imem_valid)
          w_state_next = ST_ISSUE;
      end
      default: w_state_next = ST_ISSUE;
    endcase

    if (bus.branch_taken)
      w_pc_next = w_target;
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_hold   (!bus.id_ready),
    .i_squash (bus.branch_taken),
    .i_instr  (bus.imem_rdata),
    .i_pc     (r_pc),
    .o_valid  (bus.if_valid),
    .o_instr  (bus.if_instr),
    .o_pc     (bus.if_pc)
  );

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_pc;
  assign bus.if_opcode = bus.if_instr[6:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed cycle-table bench for fetch_unit plus a PC-wrap
//            sequence on a second instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] W0 = 32'h002081B3; // add  (0110011)
  localparam logic [31:0] W1 = 32'h0000A103; // lw   (0000011)
  localparam logic [31:0] W2 = 32'h00208463; // beq  (1100011)
  localparam int NV = 33;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] rdata;
    logic        br;
    logic [63:0] tgt;
    logic        rdy;
    logic        req;
    logic [63:0] addr;
    logic        ifv;
    logic [63:0] ifpc;
    logic [31:0] instr;
  } vec_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  fetch_unit_if bus0 ();
  fetch_unit_if bus1 ();

  fetch_unit #(.RESET_PC(64'h0)) dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0)
  );

  fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  function automatic vec_t mk(logic r, logic iv, logic [31:0] rd, logic br,
                              logic [63:0] tg, logic rdy, logic req,
                              logic [63:0] ad, logic ifv, logic [63:0] ipc,
                              logic [31:0] ins);
    vec_t v;
    v.rst = r;   v.iv = iv;   v.rdata = rd; v.br = br;   v.tgt = tg;
    v.rdy = rdy; v.req = req; v.addr = ad;  v.ifv = ifv; v.ifpc = ipc;
    v.instr = ins;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //             rst iv rdata br tgt       rdy | req addr      ifv ifpc      instr
    vecs[0]  = mk(1, 0, 0,  0, 0,        1,  0, 64'h0,   0, 64'h0,   32'h0);
    vecs[1]  = mk(0, 0, 0,  0, 0,        1,  1, 64'h0,   0, 64'h0,   32'h0);
    vecs[2]  = mk(0, 1, W0, 0, 0,        1,  0, 64'h0,   0, 64'h0,   32'h0);
    vecs[3]  = mk(0, 0, 0,  0, 0,        1,  1, 64'h4,   1, 64'h0,   W0);
    vecs[4]  = mk(0, 1, W1, 0, 0,        1,  0, 64'h4,   0, 64'h0,   W0);
    vecs[5]  = mk(0, 0, 0,  0, 0,        1,  1, 64'h8,   1, 64'h4,   W1);
    vecs[6]  = mk(0, 1, W2, 0, 0,        1,  0, 64'h8,   0, 64'h4,   W1);
    vecs[7]  = mk(0, 0, 0,  0, 0,        0,  0, 64'hC,   1, 64'h8,   W2);
    vecs[8]  = mk(0, 0, 0,  0, 0,        0,  0, 64'hC,   1, 64'h8,   W2);
    vecs[9]  = mk(0, 0, 0,  0, 0,        0,  0, 64'hC,   1, 64'h8,   W2);
    vecs[10] = mk(0, 0, 0,  0, 0,        0,  0, 64'hC,   1, 64'h8,   W2);
    vecs[11] = mk(0, 0, 0,  0, 0,        0,  0, 64'hC,   1, 64'h8,   W2);
    vecs[12] = mk(0, 0, 0,  0, 0,        1,  1, 64'hC,   1, 64'h8,   W2);
    vecs[13] = mk(0, 0, 0,  1, 64'h103,  1,  0, 64'hC,   0, 64'h8,   W2);
    vecs[14] = mk(0, 0, 0,  0, 0,        1,  0, 64'h100, 0, 64'h8,   W2);
    vecs[15] = mk(0, 1, W0, 0, 0,        1,  0, 64'h100, 0, 64'h8,   W2);
    vecs[16] = mk(0, 0, 0,  0, 0,        1,  1, 64'h100, 0, 64'h8,   W2);
    vecs[17] = mk(0, 1, W1, 1, 64'h200,  1,  0, 64'h100, 0, 64'h8,   W2);
    vecs[18] = mk(0, 0, 0,  0, 0,        1,  1, 64'h200, 0, 64'h8,   W2);
    vecs[19] = mk(0, 1, W2, 0, 0,        1,  0, 64'h200, 0, 64'h8,   W2);
    vecs[20] = mk(0, 0, 0,  0, 0,        0,  0, 64'h204, 1, 64'h200, W2);
    vecs[21] = mk(0, 0, 0,  1, 64'h30A,  0,  0, 64'h204, 1, 64'h200, W2);
    vecs[22] = mk(0, 0, 0,  0, 0,        0,  1, 64'h308, 0, 64'h200, W2);
    vecs[23] = mk(0, 1, W0, 0, 0,        1,  0, 64'h308, 0, 64'h200, W2);
    vecs[24] = mk(0, 0, 0,  0, 0,        1,  1, 64'h30C, 1, 64'h308, W0);
    vecs[25] = mk(1, 0, 0,  0, 0,        1,  0, 64'h30C, 0, 64'h308, W0);
    vecs[26] = mk(0, 1, W2, 0, 0,        1,  1, 64'h0,   0, 64'h0,   32'h0);
    vecs[27] = mk(0, 1, W1, 0, 0,        1,  0, 64'h0,   0, 64'h0,   32'h0);
    vecs[28] = mk(0, 0, 0,  0, 0,        1,  1, 64'h4,   1, 64'h0,   W1);
    vecs[29] = mk(0, 0, 0,  1, 64'h400,  1,  0, 64'h4,   0, 64'h0,   W1);
    vecs[30] = mk(0, 0, 0,  1, 64'h500,  1,  0, 64'h400, 0, 64'h0,   W1);
    vecs[31] = mk(0, 1, W0, 0, 0,        1,  0, 64'h500, 0, 64'h0,   W1);
    vecs[32] = mk(0, 0, 0,  0, 0,        1,  1, 64'h500, 0, 64'h0,   W1);

    rst0 = 1'b1;
    rst1 = 1'b1;
    bus0.imem_valid = 1'b0; bus0.imem_rdata = '0; bus0.branch_taken = 1'b0;
    bus0.branch_target = '0; bus0.id_ready = 1'b1;
    bus1.imem_valid = 1'b0; bus1.imem_rdata = '0; bus1.branch_taken = 1'b0;
    bus1.branch_target = '0; bus1.id_ready = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst0               = vecs[i].rst;
      bus0.imem_valid    = vecs[i].iv;
      bus0.imem_rdata    = vecs[i].rdata;
      bus0.branch_taken  = vecs[i].br;
      bus0.branch_target = vecs[i].tgt;
      bus0.id_ready      = vecs[i].rdy;
      #1;
      chk($sformatf("row%0d imem_req", i),  64'(bus0.imem_req),  64'(vecs[i].req));
      chk($sformatf("row%0d imem_addr", i), bus0.imem_addr,      vecs[i].addr);
      chk($sformatf("row%0d if_valid", i),  64'(bus0.if_valid),  64'(vecs[i].ifv));
      chk($sformatf("row%0d if_pc", i),     bus0.if_pc,          vecs[i].ifpc);
      chk($sformatf("row%0d if_instr", i),  64'(bus0.if_instr),  64'(vecs[i].instr));
      chk($sformatf("row%0d if_opcode", i), 64'(bus0.if_opcode), 64'(vecs[i].instr[6:0]));
    end

    // PC wrap: RESET_PC at the top of the address space, second fetch at 0.
    @(negedge clk);
    #1;
    chk("wrap reset imem_req", 64'(bus1.imem_req), 64'h0);
    chk("wrap reset if_valid", 64'(bus1.if_valid), 64'h0);
    @(negedge clk);
    rst1 = 1'b0;
    #1;
    chk("wrap first imem_req",  64'(bus1.imem_req), 64'h1);
    chk("wrap first imem_addr", bus1.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    bus1.imem_valid = 1'b1;
    bus1.imem_rdata = W2;
    #1;
    chk("wrap wait imem_req", 64'(bus1.imem_req), 64'h0);
    @(negedge clk);
    bus1.imem_valid = 1'b0;
    #1;
    chk("wrap second imem_req",  64'(bus1.imem_req), 64'h1);
    chk("wrap second imem_addr", bus1.imem_addr, 64'h0);
    chk("wrap if_valid",         64'(bus1.if_valid), 64'h1);
    chk("wrap if_pc",            bus1.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap if_opcode",        64'(bus1.if_opcode), 64'(OP_BRANCH));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
